// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_LATENCY = 15;

  // Width of the wait-state counter: clog2(lat+1), never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < (lat + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // A word access is illegal when it is not 4-byte aligned or when any
  // byte-address bit above the word index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Memory-stage request/response bundle between the pipeline and the responder.
// Latency: n/a (wires only).
// Backpressure: req_ready/stall are driven by the responder (slave side).
interface dmem_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with synchronous write and registered read.
// Latency: read data valid the cycle after the enabled edge; write lands on that edge.
// Backpressure: none; the owner pulses en once per committed access.
// Ports: clk, reset (clears only the read register), en, we, addr (word index),
//        wdata, rdata (held until the next enabled edge).
module dmem_array #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // Contents are intentionally not reset.
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read is old-data on a simultaneous write; the responder never returns
  // read data for a store, so that case is not observable.
  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store at a time with LATENCY wait states.
// Latency: request accepted at edge T -> rsp_valid in the cycle after edge T+LATENCY.
// Backpressure: req_ready only in IDLE; stall holds the pipeline until the response cycle.
// Ports: clk, reset (sync, active-high), bus (dmem_if.slave: request, response, stall).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(LATENCY);

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               we_d, we_q;
  logic [31:0]        addr_d, addr_q;
  logic [31:0]        wdata_d, wdata_q;
  logic               err_d, err_q;
  logic               zero_d, zero_q;

  logic               commit;
  logic               src_we;
  logic [31:0]        src_addr;
  logic [31:0]        src_wdata;
  logic               src_err;
  logic               arr_en;
  logic               arr_we;
  logic [31:0]        arr_rdata;

  // Next state, counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // array must see the live request instead of the not-yet-captured copy.
  always_comb begin
    src_we    = we_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state_q == IDLE) begin
      src_we    = bus.req_we;
      src_addr  = bus.req_addr;
      src_wdata = bus.req_wdata;
    end
  end

  assign src_err = addr_err(src_addr, ADDR_W);

  // Reset on the commit edge wins: nothing reaches the array.
  assign arr_en = commit & ~reset;
  assign arr_we = src_we & ~src_err;

  // Response flags are latched on the commit edge and held until the next one.
  always_comb begin
    err_d  = err_q;
    zero_d = zero_q;
    if (commit) begin
      err_d  = src_err;
      zero_d = src_we | src_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (src_addr[ADDR_W+1:2]),
    .wdata (src_wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = zero_q ? 32'd0 : arr_rdata;
  // Stall drops in RESP so the pipeline advances with rsp_rdata that cycle.
  assign bus.stall     = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sel0;

  always #5 clk = ~clk;

  dmem_if b2();
  dmem_if b0();

  dmem_responder #(.LATENCY(2), .DEPTH(64), .ADDR_W(6)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  dmem_responder #(.LATENCY(0), .DEPTH(64), .ADDR_W(6)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  // Observation of whichever instance is selected.
  logic        s_ready, s_rvld, s_err, s_stall;
  logic [31:0] s_rdata;
  assign s_ready = sel0 ? b0.req_ready : b2.req_ready;
  assign s_rvld  = sel0 ? b0.rsp_valid : b2.rsp_valid;
  assign s_err   = sel0 ? b0.rsp_err   : b2.rsp_err;
  assign s_stall = sel0 ? b0.stall     : b2.stall;
  assign s_rdata = sel0 ? b0.rsp_rdata : b2.rsp_rdata;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (sel0) begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b2.req_valid = v; b2.req_we = we; b2.req_addr = a; b2.req_wdata = d;
    end
  endtask

  // Entered #1 after a rising edge with the selected instance idle.
  task automatic xact(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input int lat, input logic exp_err,
                      input logic [31:0] exp_rd);
    int k;
    int stalls;
    set_req(1'b1, we, a, d);
    #1;
    check({tag, ".ready"}, 32'(s_ready), 32'd1);
    stalls = s_stall ? 1 : 0;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the captured request must not follow.
    set_req(1'b0, ~we, 32'h0000_0004, 32'hFFFF_FFFF);
    k = 0;
    while (!s_rvld && k < 20) begin
      if (s_stall) stalls++;
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".latency"},   32'(k),       32'(lat));
    check({tag, ".stall_cnt"}, 32'(stalls),  32'(lat + 1));
    check({tag, ".rsp_valid"}, 32'(s_rvld),  32'd1);
    check({tag, ".stall_rsp"}, 32'(s_stall), 32'd0);
    check({tag, ".ready_rsp"}, 32'(s_ready), 32'd0);
    check({tag, ".err"},       32'(s_err),   32'(exp_err));
    check({tag, ".rdata"},     s_rdata,      exp_rd);
    @(posedge clk); #1;
    check({tag, ".one_shot"},  32'(s_rvld),  32'd0);
    check({tag, ".ready_idle"},32'(s_ready), 32'd1);
    check({tag, ".stall_idle"},32'(s_stall), 32'd0);
    check({tag, ".rdata_hold"},s_rdata,      exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    sel0 = 1'b0;
    reset = 1'b1;
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset.ready", 32'(s_ready), 32'd1);
    check("reset.rvld",  32'(s_rvld),  32'd0);
    check("reset.rdata", s_rdata,      32'd0);
    check("reset.err",   32'(s_err),   32'd0);
    check("reset.stall", 32'(s_stall), 32'd0);
    @(posedge clk); #1;

    xact("st10",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
    xact("ld10",   1'b0, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF);
    xact("st13",   1'b1, 32'h0000_0013, 32'h1234_5678, 2, 1'b1, 32'h0);
    xact("ld10b",  1'b0, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF);
    xact("ld100",  1'b0, 32'h0000_0100, 32'h0,         2, 1'b1, 32'h0);
    xact("ldhi",   1'b0, 32'h8000_0010, 32'h0,         2, 1'b1, 32'h0);
    xact("st20",   1'b1, 32'h0000_0020, 32'h2222_2222, 2, 1'b0, 32'h0);

    // Abort a store to 0x20 with reset while it waits.
    set_req(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("abort.stall_wait", 32'(s_stall), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort.state", 32'(u2.state_q), 32'(IDLE));
    check("abort.ready", 32'(s_ready),    32'd1);
    check("abort.stall", 32'(s_stall),    32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_rvld) seen++;
      @(posedge clk); #1;
    end
    check("abort.no_rsp", 32'(seen), 32'd0);
    xact("ld20",   1'b0, 32'h0000_0020, 32'h0,         2, 1'b0, 32'h2222_2222);

    sel0 = 1'b1;
    #1;
    xact("l0_st3c", 1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 0, 1'b0, 32'h0);
    xact("l0_ld3c", 1'b0, 32'h0000_003C, 32'h0,         0, 1'b0, 32'hA5A5_A5A5);
    xact("l0_st13", 1'b1, 32'h0000_0013, 32'h5555_5555, 0, 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests the pipelined MIPS datapath issues from its memory stage.
- Accepts one word request at a time over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then returns read data and an error flag for exactly one cycle.
- Drives a stall signal so the pipeline freezes until the response arrives; this is the memory-side end of the datapath's aluout/writedata/memwrite/readdata interface.

Parameters:
- LATENCY, 2: wait-state cycles between request acceptance and response. Legal range 0..15.
- DEPTH, 64: number of 32-bit words stored. Must be a power of two.
- ADDR_W, 6: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory-stage access present (load or store).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (aluout of the memory stage).
- req_wdata  in  32  store data (writedata).
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access, qualified by rsp_valid.
- stall  out  1  hold the pipeline: freeze PC and all pipeline registers.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0. Memory contents are not cleared.
- States:
  - IDLE: req_ready=1. On req_valid, capture we, addr and wdata, and load wait counter=LATENCY. Go to WAIT if LATENCY>0, otherwise to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==1, go to RESP on the next edge.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=0. Always returns to IDLE.
- Latency: a request accepted at edge T gives rsp_valid high in cycle T+1+LATENCY.
- Throughput: one request per LATENCY+2 cycles. No back-to-back acceptance from RESP.
- Commit point: array write and read both occur on the edge entering RESP. rsp_rdata is registered there and is 0 when captured we=1.
- Error check: rsp_err=1 when captured addr[1:0]!=0 or addr[31:ADDR_W+2]!=0. On error, the write is suppressed, rsp_rdata=0, and the response still completes normally.
- Word index: addr[ADDR_W+1:2].
- Stall: stall = (IDLE and req_valid) or WAIT. Stall is 0 in RESP so the pipeline advances with rsp_rdata that cycle.
- req_valid=0 in IDLE: stay in IDLE with stall=0.
- Captured request fields are insensitive to input changes after acceptance.
- Reset mid-operation (WAIT or at the RESP-entry edge) has priority: return to IDLE, pending write dropped, no rsp_valid.
- Read-after-write to the same word in consecutive requests returns the newly written data.
- Outputs rsp_rdata/rsp_err hold their last value outside RESP and are only meaningful with rsp_valid.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE, WAIT, RESP).
  - MAX_LATENCY=15.
  - Counter-width function: clog2(LATENCY+1), minimum 1.
  - Error-check helper function.
- One sub-module, dmem_array: DEPTH x 32 storage with synchronous write enable and registered read. It is instantiated under the FSM, which contains the FSM, counter and request capture registers.

Test Plan:
- After reset, LATENCY=2: store req_addr=0x10, wdata=0xDEADBEEF. Required: req_ready=1 at acceptance, stall high for 3 cycles, rsp_valid in cycle T+3, rsp_err=0, rsp_rdata=0.
- Then load 0x10. Required: rsp_rdata=0xDEADBEEF at T+3, stall drops in the RESP cycle.
- Misaligned store to 0x13 with wdata=0x12345678, followed by a load of 0x10. Required: first response rsp_err=1, rdata=0; the load returns 0xDEADBEEF, proving the write was suppressed.
- Out-of-range load 0x100 (DEPTH=64). Required: rsp_err=1, rsp_rdata=0.
- LATENCY=0 instance, store 0x3C=0xA5A5A5A5 then load 0x3C. Required: each response arrives the cycle after acceptance; load returns 0xA5A5A5A5.
- LATENCY=2: assert reset during WAIT of a store to 0x20=0x11111111, then load 0x20. Required: no rsp_valid for the aborted request, state IDLE, stall=0 the cycle after reset; the load does not return 0x11111111.
